// File: rtl/color_period_if.sv
// Colour-sensor period meter bus: raw pin and timebase in, averaged
// period with update strobe and timeout level out.
interface color_period_if #(
  parameter int W = 14
);
  logic         tick;
  logic         sig;
  logic [W-1:0] period;
  logic         valid;
  logic         timeout;

  modport master (
    output tick,
    output sig,
    input  period,
    input  valid,
    input  timeout
  );

  modport slave (
    input  tick,
    input  sig,
    output period,
    output valid,
    output timeout
  );
endinterface

// File: rtl/color_period_meter.sv
// Measures the colour-sensor square-wave period in timebase ticks and
// averages 2^AVG_LOG2 periods for the downstream period-to-frequency divider.
module color_period_meter #(
  parameter int W         = 14,
  parameter int AVG_LOG2  = 2,
  parameter int MIN_TICKS = 2
) (
  input logic           clk,
  input logic           rst_n,
  color_period_if.slave bus
);

  localparam int AW = W + AVG_LOG2;

  localparam logic [W-1:0] TMAX = '1;
  localparam logic [W-1:0] TMIN = W'(MIN_TICKS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEAS = 1'b1;

  logic s1;
  logic s2;
  logic s3;
  logic rise;

  logic [0:0]          state;
  logic [W-1:0]        tcnt;
  logic [W-1:0]        cap;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [AVG_LOG2-1:0] n;

  logic sat;
  logic accept;
  logic last;

  logic [W-1:0] period_q;
  logic         valid_q;
  logic         timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A tick coinciding with the edge belongs to the period being closed.
  always_comb begin
    rise    = s2 & ~s3;
    sat     = (tcnt == TMAX);
    cap     = tcnt;
    if (bus.tick && !sat) begin
      cap = tcnt + 1'b1;
    end
    accept  = rise && (cap >= TMIN);
    acc_sum = acc + {{AVG_LOG2{1'b0}}, cap};
    last    = (n == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      acc       <= '0;
      n         <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            tcnt  <= '0;
            acc   <= '0;
            n     <= '0;
            state <= MEAS;
          end else if (sat) begin
            period_q  <= TMAX;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            tcnt      <= '0;
          end else if (bus.tick && !timeout_q) begin
            // Once timed out, stay quiet until a real edge arrives.
            tcnt <= tcnt + 1'b1;
          end
        end
        MEAS: begin
          if (sat) begin
            period_q  <= TMAX;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            tcnt      <= '0;
            acc       <= '0;
            n         <= '0;
            state     <= IDLE;
          end else if (accept) begin
            tcnt <= '0;
            if (last) begin
              period_q  <= acc_sum[AW-1:AVG_LOG2];
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              acc       <= '0;
              n         <= '0;
            end else begin
              acc <= acc_sum;
              n   <= n + 1'b1;
            end
          end else begin
            tcnt <= cap;
          end
        end
      endcase
    end
  end

  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_color_period_meter.sv
// Directed bench for color_period_meter: averaging table, timeout,
// recovery, steady-state strobe spacing, mid-set reset and glitch rejection.
module tb_color_period_meter;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  color_period_if #(.W(W)) bus ();

  color_period_meter #(
    .W(W),
    .AVG_LOG2(2),
    .MIN_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
    int exp;
  } vec_t;

  vec_t tbl[6];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int vcnt = 0;
  int vcyc = 0;
  int vto = 0;
  int tdiv = 1;
  int tph = 0;
  int rel_cyc = 0;
  int base = 0;
  int c0 = 0;
  int v1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
      vto = int'(bus.timeout);
    end
    tph = (tph + 1 >= tdiv) ? 0 : tph + 1;
    bus.tick = (tph == 0);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic period_clk(input int n);
    bus.sig = 1'b1;
    step(n / 2);
    bus.sig = 1'b0;
    step(n - n / 2);
  endtask

  task automatic glitch_clk40();
    bus.sig = 1'b1;
    step(2);
    bus.sig = 1'b0;
    step(1);
    bus.sig = 1'b1;
    step(1);
    bus.sig = 1'b0;
    step(36);
  endtask

  task automatic do_reset();
    bus.sig = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    rel_cyc = cyc;
    step(4);
  endtask

  task automatic close_set(input string nm, input int exp);
    #1;
    chk({nm, " early"}, vcnt - base, 0);
    bus.sig = 1'b1;
    c0 = cyc;
    step(8);
    #1;
    chk({nm, " count"}, vcnt - base, 1);
    chk({nm, " latency"}, vcyc - c0, 3);
    chk({nm, " period"}, bus.period, exp);
    chk({nm, " timeout"}, bus.timeout, 0);
  endtask

  initial begin
    bus.sig = 1'b0;
    tbl[0] = '{100, 100, 100, 100, 100};
    tbl[1] = '{100, 101, 102, 104, 101};
    tbl[2] = '{50, 50, 50, 50, 50};
    tbl[3] = '{3, 3, 3, 3, 3};
    tbl[4] = '{7, 8, 9, 10, 8};
    tbl[5] = '{9000, 9001, 9002, 9003, 9001};

    step(2);
    #1;
    chk("reset period", bus.period, 0);
    chk("reset valid", bus.valid, 0);
    chk("reset timeout", bus.timeout, 0);

    // static low input: saturate and time out exactly once
    do_reset();
    base = vcnt;
    for (int i = 0; i < 17000 && vcnt == base; i++) @(negedge clk);
    #1;
    chk("to fire", vcnt - base, 1);
    chk("to cycle", vcyc - rel_cyc, 16384);
    chk("to period", bus.period, 16383);
    chk("to level", bus.timeout, 1);
    step(200);
    #1;
    chk("to once", vcnt - base, 1);
    chk("to hold", bus.timeout, 1);

    // recovery from timeout with 50-tick periods
    base = vcnt;
    for (int i = 0; i < 4; i++) period_clk(50);
    #1;
    chk("rec hold", bus.timeout, 1);
    close_set("rec", 50);
    chk("rec to at valid", vto, 0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      base = vcnt;
      period_clk(tbl[r].p0);
      period_clk(tbl[r].p1);
      period_clk(tbl[r].p2);
      period_clk(tbl[r].p3);
      close_set($sformatf("row%0d", r), tbl[r].exp);
    end

    // steady state: valid every 400 clk
    do_reset();
    base = vcnt;
    for (int i = 0; i < 9; i++) begin
      period_clk(100);
      if (i == 4) begin
        #1;
        chk("ss first", vcnt - base, 1);
        v1 = vcyc;
      end
    end
    #1;
    chk("ss second", vcnt - base, 2);
    chk("ss spacing", vcyc - v1, 400);
    chk("ss period", bus.period, 100);

    // reset after two accepted periods of a new set
    period_clk(100);
    period_clk(100);
    bus.sig = 1'b1;
    step(50);
    bus.sig = 1'b0;
    step(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst period", bus.period, 0);
    chk("mid rst valid", bus.valid, 0);
    chk("mid rst timeout", bus.timeout, 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    base = vcnt;
    for (int i = 0; i < 4; i++) period_clk(100);
    close_set("mid", 100);

    // glitch rejection with a tick every 4 clk
    tdiv = 4;
    do_reset();
    base = vcnt;
    period_clk(40);
    glitch_clk40();
    period_clk(40);
    glitch_clk40();
    close_set("glitch", 10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
